// File: rtl/wt_l15_store_splitter.sv
// Splits one 64-bit store with an arbitrary byte enable into naturally aligned, fully enabled beats.
// Latency: the first beat is presented the cycle after the request is accepted; beats are back-to-back.
// Backpressure: beats hold while out_ready_i is low; req_ready_o is high only when idle or on the last beat handshake.
module wt_l15_store_splitter #(
  parameter int PLEN = 56,
  parameter int ID_W = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [PLEN-1:0] req_addr_i,
  input  logic [63:0]     req_data_i,
  input  logic [7:0]      req_be_i,
  input  logic [ID_W-1:0] req_id_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PLEN-1:0] out_addr_o,
  output logic [63:0]     out_data_o,
  output logic [7:0]      out_be_o,
  output logic [1:0]      out_size_o,
  output logic [ID_W-1:0] out_id_o,
  output logic            out_last_o
);

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [PLEN-4:0] addr_q, addr_d;
  logic [63:0]     data_q, data_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      rem_q, rem_d;

  // Bookkeeping kept only to check the beat sequence of a request.
  logic [7:0]      be_q, be_d;
  logic [7:0]      cov_q, cov_d;
  logic [2:0]      nbeats_q, nbeats_d;

  // The low address bits are implied by the byte enable, so they are dropped.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[2:0];

  logic [2:0] beat_k;
  logic [7:0] beat_sh;
  logic [7:0] beat_be;
  logic [1:0] beat_size;
  logic       beat_last;

  // Pick the largest aligned, fully set chunk starting at the lowest remaining byte.
  always_comb begin
    beat_k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_q[i]) beat_k = 3'(i);
    end
    beat_sh = rem_q >> beat_k;
    if (beat_k == 3'd0 && beat_sh == 8'hFF) begin
      beat_size = 2'd3;
      beat_be   = 8'hFF;
    end else if (beat_k[1:0] == 2'd0 && beat_sh[3:0] == 4'hF) begin
      beat_size = 2'd2;
      beat_be   = 8'h0F << beat_k;
    end else if (!beat_k[0] && beat_sh[1:0] == 2'b11) begin
      beat_size = 2'd1;
      beat_be   = 8'h03 << beat_k;
    end else begin
      beat_size = 2'd0;
      beat_be   = 8'h01 << beat_k;
    end
    beat_last = (rem_q & ~beat_be) == 8'h00;
  end

  // Outputs are driven from the registered state and forced to zero when no beat is presented.
  always_comb begin
    out_valid_o = (state_q == SPLIT);
    out_addr_o  = out_valid_o ? {addr_q, beat_k} : '0;
    out_data_o  = out_valid_o ? data_q : '0;
    out_be_o    = out_valid_o ? beat_be : '0;
    out_size_o  = out_valid_o ? beat_size : '0;
    out_id_o    = out_valid_o ? id_q : '0;
    out_last_o  = out_valid_o & beat_last;
    req_ready_o = (state_q == IDLE) | (out_valid_o & out_ready_i & beat_last);
  end

  // Next-state: retire the presented beat, then let a new request overwrite the latched fields.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    id_d     = id_q;
    rem_d    = rem_q;
    be_d     = be_q;
    cov_d    = cov_q;
    nbeats_d = nbeats_q;
    if (out_valid_o && out_ready_i) begin
      rem_d    = rem_q & ~beat_be;
      cov_d    = cov_q | beat_be;
      nbeats_d = nbeats_q + 3'd1;
      if (beat_last) state_d = IDLE;
    end
    // An all-zero enable is consumed without producing any beat.
    if (req_valid_i && req_ready_o && req_be_i != 8'h00) begin
      state_d  = SPLIT;
      addr_d   = req_addr_i[PLEN-1:3];
      data_d   = req_data_i;
      id_d     = req_id_i;
      rem_d    = req_be_i;
      be_d     = req_be_i;
      cov_d    = 8'h00;
      nbeats_d = 3'd0;
    end
  end

  // State registers with synchronous reset; a reset discards any split in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      id_q     <= '0;
      rem_q    <= '0;
      be_q     <= '0;
      cov_q    <= '0;
      nbeats_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      id_q     <= id_d;
      rem_q    <= rem_d;
      be_q     <= be_d;
      cov_q    <= cov_d;
      nbeats_q <= nbeats_d;
    end
  end

  a_be_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> out_be_o != 8'h00);
  a_be_subset: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> (out_be_o & ~be_q) == 8'h00);
  a_no_overlap: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> (out_be_o & cov_q) == 8'h00);
  a_full_cover: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && out_ready_i && out_last_o) |-> (cov_q | out_be_o) == be_q);
  a_max_beats: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> nbeats_q < 3'd4);

endmodule
